// File: rtl/volley_pkg.sv
// Shared types and constants for the volley display/replay path.
// A frame packs six CW-bit coordinates, P1 first, ball last.
package volley_pkg;

    localparam int CW = 10;
    localparam int FW = 6 * CW;

    localparam int P1X = 5 * CW;
    localparam int P1Y = 4 * CW;
    localparam int P2X = 3 * CW;
    localparam int P2Y = 2 * CW;
    localparam int BX  = 1 * CW;
    localparam int BY  = 0;

    typedef struct packed {
        logic [CW-1:0] p1_x;
        logic [CW-1:0] p1_y;
        logic [CW-1:0] p2_x;
        logic [CW-1:0] p2_y;
        logic [CW-1:0] ball_x;
        logic [CW-1:0] ball_y;
    } frame_t;

    typedef enum logic [1:0] {
        ST_REC  = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Written so synthesis maps it onto a block RAM.
module frame_ram #(
    parameter  int DEPTH = 128,
    parameter  int W     = 60,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/replay_buffer.sv
// Circular frame recorder with slow-motion playback after each point.
// state | meaning
// REC   | live passthrough, frames recorded on frame_tick & rec_en
// PLAY  | stored frames replayed oldest first, SLOW ticks per frame
// DONE  | single cycle: pulse replay_done, clear recording
module replay_buffer #(
    parameter int DEPTH = 128,
    parameter int CW    = 10,
    parameter int SLOW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     rec_en,
    input  logic                     point_end,
    input  logic                     skip,
    input  logic [6*CW-1:0]          frame_in,
    output logic [6*CW-1:0]          frame_out,
    output logic                     replaying,
    output logic                     replay_done,
    output logic [$clog2(DEPTH):0]   fill
);
    import volley_pkg::*;

    localparam int AW  = $clog2(DEPTH);
    localparam int FLW = AW + 1;
    localparam int RCW = (SLOW > 1) ? $clog2(SLOW) : 1;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [FLW-1:0]  remain;
    logic [RCW-1:0]  rep_cnt;
    logic            rd_valid;
    logic [6*CW-1:0] rd_data;

    logic            rec_wr;
    logic            advance;
    logic [FLW-1:0]  fill_inc;

    assign rec_wr   = (state == ST_REC) && frame_tick && rec_en;
    assign advance  = frame_tick && (rep_cnt == RCW'(SLOW - 1));
    assign fill_inc = (fill == FLW'(DEPTH)) ? fill : fill + FLW'(1);

    frame_ram #(
        .DEPTH (DEPTH),
        .W     (6 * CW)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (rec_wr),
        .wr_addr (wr_ptr),
        .wr_data (frame_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nx    = state;
        replaying   = 1'b0;
        replay_done = 1'b0;
        case (state)
            ST_REC: begin
                if (rec_wr && point_end) begin
                    state_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                replaying = 1'b1;
                if (skip || (advance && remain == FLW'(1))) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                replay_done = 1'b1;
                state_nx    = ST_REC;
            end
            default: state_nx = ST_REC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_REC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            remain    <= '0;
            rep_cnt   <= '0;
            rd_valid  <= 1'b0;
            frame_out <= '0;
        end else begin
            state    <= state_nx;
            // The read port lags rd_ptr by a cycle; hold frame_out until it is primed.
            rd_valid <= (state == ST_PLAY);
            case (state)
                ST_REC: begin
                    frame_out <= frame_in;
                    if (rec_wr) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        fill   <= fill_inc;
                        if (point_end) begin
                            rd_ptr  <= wr_ptr + AW'(1) - fill_inc[AW-1:0];
                            remain  <= fill_inc;
                            rep_cnt <= '0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (rd_valid) begin
                        frame_out <= rd_data;
                    end
                    if (frame_tick) begin
                        if (advance) begin
                            rep_cnt <= '0;
                            rd_ptr  <= rd_ptr + AW'(1);
                            remain  <= remain - FLW'(1);
                        end else begin
                            rep_cnt <= rep_cnt + RCW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    frame_out <= frame_in;
                    fill      <= '0;
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_replay_buffer.sv
// Self-checking bench for replay_buffer against a queue-based recording model.
module tb_replay_buffer;

    localparam int DEPTH = 128;
    localparam int CW    = 10;
    localparam int SLOW  = 2;
    localparam int FW    = 6 * CW;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_tick;
    logic          rec_en;
    logic          point_end;
    logic          skip;
    logic [FW-1:0] frame_in;
    logic [FW-1:0] frame_out;
    logic          replaying;
    logic          replay_done;
    logic [AW:0]   fill;

    int checks = 0;
    int errors = 0;

    // Model: the frames currently held, oldest first, at most DEPTH of them.
    logic [FW-1:0] mdl_q [$];

    replay_buffer #(.DEPTH(DEPTH), .CW(CW), .SLOW(SLOW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .rec_en      (rec_en),
        .point_end   (point_end),
        .skip        (skip),
        .frame_in    (frame_in),
        .frame_out   (frame_out),
        .replaying   (replaying),
        .replay_done (replay_done),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] rand_frame();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One frame tick; spaced by idle cycles unless it triggers playback.
    task automatic rec_tick(input logic [FW-1:0] fr, input logic en, input logic pe);
        frame_in   = fr;
        rec_en     = en;
        point_end  = pe;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        point_end  = 1'b0;
        if (en) begin
            mdl_q.push_back(fr);
            if (mdl_q.size() > DEPTH) void'(mdl_q.pop_front());
        end
        if (!(en && pe)) begin
            checks++;
            if (fill !== (AW+1)'(mdl_q.size()))
                $display("FAIL rec_fill got %0d exp %0d", fill, mdl_q.size());
            if (fill !== (AW+1)'(mdl_q.size())) errors++;
            idle(3);
        end
    endtask

    task automatic check_done();
        logic [FW-1:0] fr;
        checks++;
        if (replay_done !== 1'b1 || replaying !== 1'b0) begin
            $display("FAIL done_pulse got done=%0b rep=%0b exp done=1 rep=0", replay_done, replaying);
            errors++;
        end
        fr = rand_frame();
        frame_in = fr;
        cyc();
        checks++;
        if (replay_done !== 1'b0 || fill !== '0 || replaying !== 1'b0) begin
            $display("FAIL after_done got done=%0b fill=%0d rep=%0b exp 0 0 0", replay_done, fill, replaying);
            errors++;
        end
        fr = rand_frame();
        frame_in = fr;
        cyc();
        checks++;
        if (frame_out !== fr || replay_done !== 1'b0) begin
            $display("FAIL passthrough got %0h done=%0b exp %0h done=0", frame_out, replay_done, fr);
            errors++;
        end
        mdl_q.delete();
    endtask

    // Called in the first PLAY cycle; walks every expected tick of playback.
    task automatic run_playback(input bit skip_last);
        logic [FW-1:0] exp_q [$];
        foreach (mdl_q[i]) repeat (SLOW) exp_q.push_back(mdl_q[i]);
        checks++;
        if (replaying !== 1'b1) begin
            $display("FAIL replay_start got %0b exp 1", replaying);
            errors++;
        end
        foreach (exp_q[i]) begin
            idle(3);
            checks++;
            if (frame_out !== exp_q[i] || replaying !== 1'b1) begin
                $display("FAIL play_frame[%0d] got %0h rep=%0b exp %0h rep=1", i, frame_out, replaying, exp_q[i]);
                errors++;
            end
            frame_in   = rand_frame();
            rec_en     = 1'($urandom_range(0, 1));
            point_end  = 1'($urandom_range(0, 1));
            skip       = skip_last && (i == exp_q.size() - 1);
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            point_end  = 1'b0;
            skip       = 1'b0;
        end
        check_done();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_in = rand_frame();
        idle(2);
        checks++;
        if (frame_out !== '0 || replaying !== 1'b0 || replay_done !== 1'b0 || fill !== '0) begin
            $display("FAIL reset got out=%0h rep=%0b done=%0b fill=%0d exp all 0",
                     frame_out, replaying, replay_done, fill);
            errors++;
        end
        rst = 1'b0;
        mdl_q.delete();
        cyc();
    endtask

    task automatic test_basic_replay();
        for (int k = 1; k <= 10; k++) rec_tick(FW'(k), 1'b1, k == 10);
        run_playback(1'b0);
    endtask

    task automatic test_wrap();
        for (int k = 1; k <= 200; k++) rec_tick(FW'(k), 1'b1, k == 200);
        run_playback(1'b0);
    endtask

    task automatic test_skip();
        for (int k = 0; k < 12; k++) rec_tick(rand_frame(), 1'b1, k == 11);
        idle(4);
        skip = 1'b1;
        cyc();
        skip = 1'b0;
        check_done();
        idle(3);
        checks++;
        if (replay_done !== 1'b0) begin
            $display("FAIL skip_single_pulse got %0b exp 0", replay_done);
            errors++;
        end
    endtask

    task automatic test_reset_mid_play();
        for (int k = 0; k < 8; k++) rec_tick(rand_frame(), 1'b1, k == 7);
        idle(10);
        frame_in = rand_frame() | FW'(1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (replaying !== 1'b0 || fill !== '0 || frame_out !== '0 || replay_done !== 1'b0) begin
            $display("FAIL reset_mid_play got rep=%0b fill=%0d out=%0h done=%0b exp 0",
                     replaying, fill, frame_out, replay_done);
            errors++;
        end
        mdl_q.delete();
        idle(2);
    endtask

    task automatic test_rec_disabled();
        for (int k = 0; k < 3; k++) rec_tick(rand_frame(), 1'b0, 1'b1);
        checks++;
        if (replaying !== 1'b0) begin
            $display("FAIL empty_point_end got rep=%0b exp 0", replaying);
            errors++;
        end
        for (int k = 0; k < 3; k++) rec_tick(rand_frame(), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) rec_tick(rand_frame(), 1'b0, 1'b1);
        checks++;
        if (replaying !== 1'b0 || fill !== (AW+1)'(3)) begin
            $display("FAIL disabled_no_replay got rep=%0b fill=%0d exp 0 3", replaying, fill);
            errors++;
        end
        rec_tick(rand_frame(), 1'b1, 1'b1);
        run_playback(1'b0);
    endtask

    task automatic test_skip_last();
        for (int k = 0; k < 5; k++) rec_tick(rand_frame(), 1'b1, k == 4);
        run_playback(1'b1);
        idle(2);
        checks++;
        if (replay_done !== 1'b0 || replaying !== 1'b0) begin
            $display("FAIL skip_last_extra got done=%0b rep=%0b exp 0 0", replay_done, replaying);
            errors++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 160);
            for (int k = 0; k < n; k++) rec_tick(rand_frame(), 1'($urandom_range(0, 3) != 0), 1'b0);
            rec_tick(rand_frame(), 1'b1, 1'b1);
            run_playback(1'b0);
        end
    endtask

    initial begin
        frame_tick = 1'b0;
        rec_en     = 1'b0;
        point_end  = 1'b0;
        skip       = 1'b0;
        frame_in   = '0;
        rst        = 1'b1;
        test_reset();
        test_basic_replay();
        test_wrap();
        test_skip();
        test_reset_mid_play();
        test_rec_disabled();
        test_skip_last();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/replay_buffer.md
# replay_buffer

Circular frame recorder and slow-motion playback engine between the game-state display registers and the render stage. While a rally is live it records the packed positions of P1, P2 and the ball once per 60 Hz frame. When a point ends it replays the last up-to-DEPTH frames at reduced speed and drives `replaying` so the physics engine and score logic hold. Outside replay its frame output is a one-cycle-registered passthrough of the live positions.

## Interface
- DEPTH, 128, frames stored; power of two, ≥ 4.
- CW, 10, coordinate width.
- SLOW, 2, frame ticks each recorded frame is shown during playback; ≥ 1.
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per display frame.
- rec_en  in  1  high while game state is IN_GAME.
- point_end  in  1  physics game_over flag; sampled only when frame_tick is high.
- skip  in  1  debounced one-cycle pulse that aborts playback.
- frame_in  in  6*CW  {p1_x, p1_y, p2_x, p2_y, ball_x, ball_y}, MSB first.
- frame_out  out  6*CW  same packing; live or replayed.
- replaying  out  1  high throughout playback.
- replay_done  out  1  one-cycle pulse on leaving playback.
- fill  out  clog2(DEPTH)+1  frames currently held.

## Operation
- States: REC, PLAY, DONE.
- REC:
  - On frame_tick & rec_en, write frame_in at wr_ptr, increment wr_ptr mod DEPTH, and increment fill (saturates at DEPTH; oldest frame is overwritten).
  - When rec_en is low, nothing is written.
  - frame_out <= frame_in every cycle.
- REC→PLAY: on frame_tick & rec_en & point_end.
  - The triggering frame is written first.
  - rd_ptr <= (wr_ptr + 1 − (fill+1 sat DEPTH)) mod DEPTH, i.e. the oldest stored frame.
  - remain <= fill after this write.
  - rep_cnt <= 0.
- PLAY:
  - Memory is read at rd_ptr with 1-cycle latency; frame_out <= mem data. No writes occur.
  - On each frame_tick, rep_cnt increments. When rep_cnt reaches SLOW−1, it clears, rd_ptr advances (mod DEPTH) and remain decrements.
  - Transition to DONE when remain reaches 0, or on skip in any cycle.
- DONE (one cycle):
  - replay_done = 1.
  - fill, wr_ptr and rd_ptr clear.
  - Next state REC.
- point_end while fill = 0 and rec_en low: ignored.
- rec_en low during PLAY: playback continues.
- skip together with the last advance: single DONE, single replay_done pulse.

## Timing
- Reset values:
  - state = REC
  - frame_out = 0
  - replaying = 0
  - replay_done = 0
  - fill = 0
  - all pointers = 0
- Reset mid-PLAY returns to REC the next cycle. The recording is discarded.
- replaying rises the cycle after the triggering frame_tick and falls in the DONE cycle.
- First replayed frame appears on frame_out 2 cycles after entering PLAY (address set, then registered read), and before the next frame_tick.
- Playback length is fill × SLOW frame ticks. With fill = DEPTH = 128 and SLOW = 2, that is 256 ticks (about 4.3 s).
- Passthrough latency is 1 cycle.
- fill arithmetic is unsigned and saturating. Pointer arithmetic wraps mod DEPTH.

## Structure
- Shared package `volley_pkg` holds:
  - CW and the frame field offsets (P1X … BY)
  - `frame_t` packed typedef
  - state encoding
- One sub-module `frame_ram`: simple dual-port, synchronous read, DEPTH × 6·CW, inferable as BRAM.
- The FSM, pointers and counters live in `replay_buffer`.

## Test plan
- Reset, then 10 frames with rec_en = 1 and frame_in = k on frame k; point_end on frame 10 → replaying = 1, frame_out shows 1,1,2,2,…,10,10 on successive frame ticks (SLOW = 2), then replay_done pulses and fill returns to 0.
- 200 recorded frames, then point_end (DEPTH = 128) → playback starts at frame 73 and ends at 200; 256 ticks long.
- skip 5 cycles into PLAY → DONE next cycle, replay_done single pulse, passthrough resumes.
- rst asserted mid-PLAY → the following cycle shows replaying = 0, fill = 0, frame_out = 0, state REC.
- rec_en = 0 with frame_tick and point_end pulses → no write, no replay, fill unchanged.
- skip coincident with the final advance → exactly one replay_done pulse, no extra frame shown.
